// File: rtl/core_pkg.sv
// Shared types and helpers for the I/O bus responder and related gate-array blocks.
//   io_bus_st_t    : bus responder state encoding
//   BERR_UNMAP_ALL : all-ones source for the "unmapped" BERR_IDX code (slice to width)
//   berr_idx_w()   : width of BERR_IDX for a given slave count
package core_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2,
      DONE = 2'd3
   } io_bus_st_t;

   // Sliced down to BERR_IDX width; all-ones flags an unmapped access.
   localparam logic [31:0] BERR_UNMAP_ALL = 32'hFFFF_FFFF;

   // One extra bit beyond the slave index so all-ones never aliases a real slave.
   function automatic int berr_idx_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder.
//   req   : N active-high request lines, bit 0 has highest priority
//   idx   : index of the lowest set request (0 when none set)
//   valid : at least one request is set
module prio_enc #(
   parameter int N = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top down so the lowest active index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_bus_ctl.sv
// I/O-space bus responder between the V810 CPU bus and NSLV peripheral chip-selects.
// Registers the slave select at cycle start, enforces per-slave minimum wait states,
// then waits on the slave's BUSYn; a watchdog ends stalled or unmapped cycles with BERR.
//   CLK, RESn        : clock, asynchronous active-low reset
//   CE               : CPU clock enable, all state advances only when high
//   BCYSTn, RW       : bus-cycle start strobe (active low), 1=read / 0=write
//   IO_CEn, CS_N     : I/O space decode and per-slave chip selects (active low)
//   SLV_DO           : slave read data, slave i at [i*DW +: DW]
//   SLV_BUSYN        : per-slave ready, 1 = can complete
//   WAITS            : static minimum wait states, slave i at [i*WCW +: WCW]
//   DO               : registered read data to CPU
//   READYn           : cycle completion, low for one CE cycle
//   BERR, BERR_IDX   : one-CE-cycle error pulse and index of last erroring slave
module io_bus_ctl
   import core_pkg::*;
#(
   parameter int             NSLV      = 8,
   parameter int             DW        = 16,
   parameter int             WCW       = 4,
   parameter int             TMO       = 255,
   parameter logic [DW-1:0]  UNMAP_VAL = '0
) (
   input  logic                        CLK,
   input  logic                        RESn,
   input  logic                        CE,
   input  logic                        BCYSTn,
   input  logic                        RW,
   input  logic                        IO_CEn,
   input  logic [NSLV-1:0]             CS_N,
   input  logic [NSLV*DW-1:0]          SLV_DO,
   input  logic [NSLV-1:0]             SLV_BUSYN,
   input  logic [NSLV*WCW-1:0]         WAITS,
   output logic [DW-1:0]               DO,
   output logic                        READYn,
   output logic                        BERR,
   output logic [berr_idx_w(NSLV)-1:0] BERR_IDX
);

   localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int IW = berr_idx_w(NSLV);
   localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam logic [TW-1:0]  TCNT_MAX  = '1;
   localparam logic [TW-1:0]  TMO_V     = TW'(TMO);
   localparam logic [IW-1:0]  UNMAP_IDX = BERR_UNMAP_ALL[IW-1:0];

   io_bus_st_t      state_reg;
   logic [SW-1:0]   sel_reg;
   logic            rw_reg;
   logic            unmap_reg;
   logic [WCW-1:0]  wcnt_reg;
   logic [TW-1:0]   tcnt_reg;

   logic [SW-1:0]   enc_idx;
   logic            enc_valid;

   prio_enc #(.N(NSLV)) u_prio_enc (
      .req   (~CS_N),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         rw_reg    <= 1'b0;
         unmap_reg <= 1'b0;
         wcnt_reg  <= '0;
         tcnt_reg  <= '0;
         DO        <= '0;
         READYn    <= 1'b1;
         BERR      <= 1'b0;
         BERR_IDX  <= '0;
      end else if (CE) begin
         case (state_reg)
            IDLE: begin
               if (!BCYSTn && !IO_CEn) begin
                  rw_reg    <= RW;
                  tcnt_reg  <= '0;
                  state_reg <= WAIT;
                  if (enc_valid) begin
                     sel_reg   <= enc_idx;
                     unmap_reg <= 1'b0;
                     wcnt_reg  <= WAITS[int'(enc_idx)*WCW +: WCW];
                  end else begin
                     // Unmapped cycles pass through WAIT for one CE cycle so the
                     // error completes two edges after the strobe.
                     sel_reg   <= '0;
                     unmap_reg <= 1'b1;
                     wcnt_reg  <= '0;
                  end
               end
            end
            WAIT: begin
               if (unmap_reg) begin
                  state_reg <= ERR;
               end else if (CS_N[sel_reg]) begin
                  // Select withdrawn: drop the cycle silently.
                  state_reg <= IDLE;
               end else if (wcnt_reg != '0) begin
                  wcnt_reg <= wcnt_reg - WCW'(1);
               end else if (SLV_BUSYN[sel_reg]) begin
                  if (rw_reg)
                     DO <= SLV_DO[int'(sel_reg)*DW +: DW];
                  READYn    <= 1'b0;
                  state_reg <= DONE;
               end else if (TMO != 0 && tcnt_reg == TMO_V) begin
                  state_reg <= ERR;
               end else if (tcnt_reg != TCNT_MAX) begin
                  tcnt_reg <= tcnt_reg + TW'(1);
               end
            end
            ERR: begin
               if (rw_reg)
                  DO <= UNMAP_VAL;
               READYn    <= 1'b0;
               BERR      <= 1'b1;
               BERR_IDX  <= unmap_reg ? UNMAP_IDX : IW'(sel_reg);
               state_reg <= DONE;
            end
            DONE: begin
               READYn    <= 1'b1;
               BERR      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_ctl.sv
// Scoreboard bench for io_bus_ctl: stimulus pushes expected completions into a queue,
// a negedge monitor pops and compares each READYn pulse (data, BERR, index, latency, width).
module tb_io_bus_ctl;

   localparam int NSLV = 8;
   localparam int DW   = 16;
   localparam int WCW  = 4;
   localparam int IW   = $clog2(NSLV) + 1;

   typedef struct {
      logic [DW-1:0] do_v;
      logic          berr;
      logic [IW-1:0] idx;
      int            edge_no;   // -1: latency not checked
      int            width;     // READYn low time in CLK periods
   } exp_t;

   logic                 CLK = 1'b0;
   logic                 RESn = 1'b0;
   logic                 CE = 1'b1;
   logic                 BCYSTn = 1'b1;
   logic                 RW = 1'b1;
   logic                 IO_CEn = 1'b1;
   logic [NSLV-1:0]      CS_N = '1;
   logic [NSLV*DW-1:0]   SLV_DO = '0;
   logic [NSLV-1:0]      SLV_BUSYN = '1;
   logic [NSLV*WCW-1:0]  WAITS = '0;

   logic [DW-1:0]        DO, DO0;
   logic                 READYn, READYn0;
   logic                 BERR, BERR0;
   logic [IW-1:0]        BERR_IDX, BERR_IDX0;

   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   exp_t sb[$];
   exp_t cur;
   logic have_cur = 1'b0;
   logic in_pulse = 1'b0;
   int   width = 0;
   logic [IW-1:0] exp_idx = '0;

   io_bus_ctl #(.NSLV(NSLV), .DW(DW), .WCW(WCW), .TMO(16), .UNMAP_VAL(16'h0000)) u_dut (
      .CLK(CLK), .RESn(RESn), .CE(CE), .BCYSTn(BCYSTn), .RW(RW), .IO_CEn(IO_CEn),
      .CS_N(CS_N), .SLV_DO(SLV_DO), .SLV_BUSYN(SLV_BUSYN), .WAITS(WAITS),
      .DO(DO), .READYn(READYn), .BERR(BERR), .BERR_IDX(BERR_IDX)
   );

   // Watchdog-disabled copy sharing all inputs.
   io_bus_ctl #(.NSLV(NSLV), .DW(DW), .WCW(WCW), .TMO(0), .UNMAP_VAL(16'h0000)) u_dut0 (
      .CLK(CLK), .RESn(RESn), .CE(CE), .BCYSTn(BCYSTn), .RW(RW), .IO_CEn(IO_CEn),
      .CS_N(CS_N), .SLV_DO(SLV_DO), .SLV_BUSYN(SLV_BUSYN), .WAITS(WAITS),
      .DO(DO0), .READYn(READYn0), .BERR(BERR0), .BERR_IDX(BERR_IDX0)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_cnt = edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // Monitor: one line per completed transaction.
   always @(negedge CLK) begin
      if (READYn === 1'b0) begin
         if (!in_pulse) begin
            in_pulse = 1'b1;
            width    = 1;
            if (sb.size() == 0) begin
               have_cur = 1'b0;
               checks++;
               errors++;
               $display("FAIL unexpected_ready: READYn low at edge %0d with no cycle pending", edge_cnt);
            end else begin
               cur      = sb.pop_front();
               have_cur = 1'b1;
               $display("txn edge=%0d DO=%h BERR=%b BERR_IDX=%h", edge_cnt, DO, BERR, BERR_IDX);
               chk("do", 32'(DO), 32'(cur.do_v));
               chk("berr", 32'(BERR), 32'(cur.berr));
               chk("berr_idx", 32'(BERR_IDX), 32'(cur.idx));
               if (cur.edge_no >= 0)
                  chk("latency_edge", edge_cnt, cur.edge_no);
            end
         end else begin
            width++;
         end
      end else if (in_pulse) begin
         in_pulse = 1'b0;
         if (have_cur)
            chk("ready_width", width, cur.width);
      end
   end

   // Start a cycle at the current point (just after a negedge); lat is edges after the
   // strobe-sampling edge, -1 to skip the latency check.
   task automatic issue(input logic rw, input logic [NSLV-1:0] csn, input logic push,
                        input logic [DW-1:0] do_v, input logic berr, input int lat);
      exp_t e;
      CS_N   = csn;
      RW     = rw;
      IO_CEn = 1'b0;
      BCYSTn = 1'b0;
      if (berr)
         exp_idx = (csn == '1) ? '1 : IW'(1);
      e.do_v    = do_v;
      e.berr    = berr;
      e.idx     = exp_idx;
      e.edge_no = (lat < 0) ? -1 : edge_cnt + 1 + lat;
      e.width   = 1;
      if (push)
         sb.push_back(e);
      @(negedge CLK); #1;
      BCYSTn = 1'b1;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !in_pulse) break;
         @(negedge CLK); #1;
      end
      if (sb.size() != 0 || in_pulse) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d completions still pending, expected 0", name, sb.size());
         sb.delete();
      end
      CS_N   = '1;
      IO_CEn = 1'b1;
      RW     = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK); #1;
      end
   endtask

   initial begin
      int lows;
      logic [NSLV-1:0] csn;

      // Reset state
      idle(3);
      chk("rst_do", 32'(DO), 32'h0);
      chk("rst_readyn", 32'(READYn), 32'h1);
      chk("rst_berr", 32'(BERR), 32'h0);
      chk("rst_berr_idx", 32'(BERR_IDX), 32'h0);
      RESn = 1'b1;
      idle(2);

      // Read slave 3, no wait states
      SLV_DO[3*DW +: DW] = 16'hA55A;
      issue(1'b1, ~(8'h01 << 3), 1'b1, 16'hA55A, 1'b0, 1);
      wait_done("read_s3");

      // Slaves 2 and 5 together: slave 2 wins, 3 wait states, BUSYn toggling ignored
      WAITS[2*WCW +: WCW] = 4'd3;
      SLV_DO[2*DW +: DW]  = 16'h1234;
      SLV_DO[5*DW +: DW]  = 16'h5555;
      issue(1'b1, ~8'b0010_0100, 1'b1, 16'h1234, 1'b0, 4);
      SLV_BUSYN[2] = 1'b0;
      idle(2);
      SLV_BUSYN[2] = 1'b1;
      wait_done("prio");

      // Timeout on slave 1: 16 stall cycles then BERR; watchdog-less copy never completes
      SLV_BUSYN[1] = 1'b0;
      issue(1'b1, ~8'h02, 1'b1, 16'h0000, 1'b1, 18);
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !in_pulse) break;
         @(negedge CLK); #1;
      end
      chk("tmo_pending", sb.size(), 0);
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         if (READYn0 !== 1'b1 || BERR0 !== 1'b0) lows++;
         @(negedge CLK); #1;
      end
      chk("tmo0_no_complete", lows, 0);
      CS_N = '1;
      IO_CEn = 1'b1;
      SLV_BUSYN[1] = 1'b1;
      idle(3);

      // Strobe while busy is ignored
      WAITS[0*WCW +: WCW] = 4'd4;
      SLV_DO[0*DW +: DW]  = 16'h0F0F;
      issue(1'b1, ~8'h01, 1'b1, 16'h0F0F, 1'b0, 5);
      idle(1);
      BCYSTn = 1'b0;
      RW     = 1'b0;
      idle(1);
      BCYSTn = 1'b1;
      wait_done("bcyst_ignored");

      // Unmapped read
      issue(1'b1, '1, 1'b1, 16'h0000, 1'b1, 2);
      wait_done("unmapped");

      // Preload DO via slave 4 read
      SLV_DO[4*DW +: DW] = 16'hBEEF;
      issue(1'b1, ~8'h10, 1'b1, 16'hBEEF, 1'b0, 1);
      wait_done("read_s4");

      // Write to slave 4 with CE 1-of-5: DO holds, READYn spans 5 CLKs
      begin
         exp_t e;
         SLV_DO[4*DW +: DW] = 16'h1111;
         e.do_v = 16'hBEEF; e.berr = 1'b0; e.idx = exp_idx; e.edge_no = -1; e.width = 5;
         sb.push_back(e);
         CS_N = ~8'h10; RW = 1'b0; IO_CEn = 1'b0; BCYSTn = 1'b0;
         for (int c = 0; c < 80; c++) begin
            if (c > 0 && sb.size() == 0 && !in_pulse) break;
            CE = (c % 5 == 0);
            @(negedge CLK); #1;
            if (c == 4) BCYSTn = 1'b1;
         end
         CE = 1'b1;
         BCYSTn = 1'b1;
         wait_done("write_ce");
      end

      // Abort: CS_N[sel] withdrawn mid-WAIT
      issue(1'b1, ~8'h04, 1'b0, 16'h0000, 1'b0, -1);
      CS_N = '1;
      idle(10);
      chk("abort_do", 32'(DO), 32'hBEEF);
      chk("abort_readyn", 32'(READYn), 32'h1);
      IO_CEn = 1'b1;

      // Reset during WAIT
      WAITS[6*WCW +: WCW] = 4'd5;
      SLV_DO[6*DW +: DW]  = 16'h7777;
      issue(1'b1, ~8'h40, 1'b0, 16'h0000, 1'b0, -1);
      idle(1);
      RESn = 1'b0;
      #1;
      chk("midrst_do", 32'(DO), 32'h0);
      chk("midrst_readyn", 32'(READYn), 32'h1);
      idle(1);
      RESn = 1'b1;
      idle(10);
      CS_N = '1;
      IO_CEn = 1'b1;
      chk("postrst_do", 32'(DO), 32'h0);
      chk("postrst_berr_idx", 32'(BERR_IDX), 32'h0);
      exp_idx = '0;

      // Recovery read after reset
      csn = ~8'h08;
      issue(1'b1, csn, 1'b1, 16'hA55A, 1'b0, 1);
      wait_done("recover");

      idle(3);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
